// File: rtl/dda_spi_ctrl.sv
// SPI command decoder for the DDA core: turns a byte stream from an SPI slave
// into parameter-register writes, coherent x/y snapshots and run/halt/step/restart
// control, and answers every received byte with exactly one transmit byte.
module dda_spi_ctrl #(
  parameter int N        = 16,
  parameter int REG_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  input  logic [N-1:0]          x,
  input  logic [N-1:0]          y,
  output logic [REG_SIZE*N-1:0] params,
  output logic                  dda_en,
  output logic                  dda_rst
);

  localparam int         AW         = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
  localparam logic [7:0] REG_SIZE_B = 8'(REG_SIZE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    READ = 3'd4
  } state_t;

  typedef enum logic [7:0] {
    OP_WRITE   = 8'h01,
    OP_READ    = 8'h02,
    OP_RUN     = 8'h03,
    OP_HALT    = 8'h04,
    OP_STEP    = 8'h05,
    OP_RESTART = 8'h06,
    OP_CLRERR  = 8'h07
  } opcode_t;

  // Power-up contents of the parameter registers: icx, icy, k, d.
  function automatic logic [N-1:0] reset_value(input int i);
    case (i)
      0:       return N'(16'hC000);
      1:       return N'(16'h14CD);
      2:       return N'(16'h14DD);
      3:       return N'(16'h14DD);
      default: return '0;
    endcase
  endfunction

  state_t         state, state_d;
  logic [2:0]     idx, idx_d;
  logic           err, err_d;
  logic [AW-1:0]  addr, addr_d;
  logic [7:0]     hi, hi_d;
  logic [2*N-1:0] snap, snap_d;
  logic           tx_dv_d;
  logic [7:0]     tx_byte_d;
  logic           dda_en_d, dda_rst_d;
  logic           step_pulse, step_pulse_d;  // dda_en is high only because of a STEP
  logic           step_pend, step_pend_d;    // a STEP arrived during a step pulse
  logic           wr_en;
  logic           use_status;
  logic [N-1:0]   regs [REG_SIZE];

  // Next-state, response byte and control decode for one received byte.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d      = state;
    idx_d        = idx;
    err_d        = err;
    addr_d       = addr;
    hi_d         = hi;
    snap_d       = snap;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte;
    dda_en_d     = dda_en;
    dda_rst_d    = 1'b0;
    step_pulse_d = step_pulse;
    step_pend_d  = step_pend;
    wr_en        = 1'b0;
    use_status   = 1'b1;

    // A step pulse lasts one cycle; a queued step fires only after a low cycle.
    if (step_pulse) begin
      dda_en_d     = 1'b0;
      step_pulse_d = 1'b0;
    end else if (step_pend) begin
      dda_en_d     = 1'b1;
      step_pulse_d = 1'b1;
      step_pend_d  = 1'b0;
    end

    if (rx_dv) begin
      tx_dv_d = 1'b1;
      case (state)
        IDLE: begin
          case (rx_byte)
            OP_WRITE: state_d = ADDR;
            OP_READ: begin
              snap_d     = {x, y};
              tx_byte_d  = x[N-1 -: 8];
              use_status = 1'b0;
              idx_d      = 3'd1;
              state_d    = READ;
            end
            OP_RUN: begin
              dda_en_d     = 1'b1;
              step_pulse_d = 1'b0;
              step_pend_d  = 1'b0;
            end
            OP_HALT: begin
              dda_en_d     = 1'b0;
              step_pulse_d = 1'b0;
              step_pend_d  = 1'b0;
            end
            OP_STEP: begin
              if (step_pulse) begin
                step_pend_d = 1'b1;
              end else if (!dda_en && !step_pend) begin
                dda_en_d     = 1'b1;
                step_pulse_d = 1'b1;
              end
            end
            OP_RESTART: dda_rst_d = 1'b1;
            OP_CLRERR:  err_d     = 1'b0;
            default:    err_d     = 1'b1;
          endcase
        end
        ADDR: begin
          if (rx_byte < REG_SIZE_B) begin
            addr_d  = rx_byte[AW-1:0];
            state_d = DHI;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DHI: begin
          hi_d    = rx_byte;
          state_d = DLO;
        end
        DLO: begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
        READ: begin
          use_status = 1'b0;
          case (idx)
            3'd1:    tx_byte_d = snap[2*N-9  -: 8];
            3'd2:    tx_byte_d = snap[2*N-17 -: 8];
            3'd3:    tx_byte_d = snap[7:0];
            default: tx_byte_d = 8'h00;
          endcase
          if (idx >= 3'd4) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (use_status) tx_byte_d = {dda_en_d, err_d, 3'b000, state_d};
    end
  end

  // State and output registers; reset wins over any byte received in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      err        <= 1'b0;
      addr       <= '0;
      hi         <= 8'h00;
      snap       <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      dda_en     <= 1'b1;
      dda_rst    <= 1'b0;
      step_pulse <= 1'b0;
      step_pend  <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      err        <= err_d;
      addr       <= addr_d;
      hi         <= hi_d;
      snap       <= snap_d;
      tx_dv      <= tx_dv_d;
      tx_byte    <= tx_byte_d;
      dda_en     <= dda_en_d;
      dda_rst    <= dda_rst_d;
      step_pulse <= step_pulse_d;
      step_pend  <= step_pend_d;
    end
  end

  // Parameter register file, written only on the final data byte of a WRITE.
  always_ff @(posedge clk) begin
    // NOTE: this small register file is reset because the DDA needs defined ICs and gains at power-up.
    if (!rst_n) begin
      for (int i = 0; i < REG_SIZE; i++) regs[i] <= reset_value(i);
    end else if (wr_en) begin
      regs[addr] <= {hi, rx_byte};
    end
  end

  for (genvar g = 0; g < REG_SIZE; g++) begin : g_params
    assign params[g*N +: N] = regs[g];
  end

endmodule

// File: tb/tb_dda_spi_ctrl.sv
// Directed bench for dda_spi_ctrl: every sent byte pushes its expected reply
// byte to a queue, and a negedge monitor pops and compares each tx_dv pulse.
module tb_dda_spi_ctrl;

  localparam int          N          = 16;
  localparam int          REG_SIZE   = 4;
  localparam logic [63:0] PARAMS_RST = 64'h14DD_14DD_14CD_C000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  rx_dv;
  logic [7:0]            rx_byte;
  logic                  tx_dv;
  logic [7:0]            tx_byte;
  logic [N-1:0]          x;
  logic [N-1:0]          y;
  logic [REG_SIZE*N-1:0] params;
  logic                  dda_en;
  logic                  dda_rst;

  int vectors     = 0;
  int miscompares = 0;
  int tx_pulses   = 0;
  int rx_sent     = 0;
  int dda_rst_cnt = 0;
  logic [7:0] exp_q[$];

  dda_spi_ctrl #(.N(N), .REG_SIZE(REG_SIZE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_dv   (rx_dv),
    .rx_byte (rx_byte),
    .tx_dv   (tx_dv),
    .tx_byte (tx_byte),
    .x       (x),
    .y       (y),
    .params  (params),
    .dda_en  (dda_en),
    .dda_rst (dda_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise rx_dv now and record the reply byte the controller owes for it.
  task automatic strobe(input logic [7:0] b, input logic [7:0] e);
    rx_dv   = 1'b1;
    rx_byte = b;
    exp_q.push_back(e);
    rx_sent++;
  endtask

  // One isolated byte; returns on the negedge where the t+1 response is visible.
  task automatic send(input logic [7:0] b, input logic [7:0] e);
    @(negedge clk);
    strobe(b, e);
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  // Reply-byte scoreboard and dda_rst pulse counter, sampled away from the active edge.
  always @(negedge clk) begin
    if (dda_rst === 1'b1) dda_rst_cnt++;
    if (tx_dv === 1'b1) begin
      tx_pulses++;
      check("tx_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] xv, yv;
    int          rst_mark;

    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    x       = '0;
    y       = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_dv",   64'(tx_dv),   64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'h00);
    check("rst_dda_en",  64'(dda_en),  64'd1);
    check("rst_dda_rst", 64'(dda_rst), 64'd0);
    check("rst_params",  params,       PARAMS_RST);
    rst_n = 1'b1;

    // WRITE params[2] = 0x1234; nothing changes until the last byte.
    send(8'h01, 8'h81);
    send(8'h02, 8'h82);
    send(8'h12, 8'h83);
    check("partial_write", params, PARAMS_RST);
    send(8'h34, 8'h80);
    check("write_p2", params, 64'h14DD_1234_14CD_C000);

    // READ with x/y changed after the opcode; dummies that look like opcodes are ignored.
    x = 16'hC000;
    y = 16'h14CD;
    send(8'h02, 8'hC0);
    x = 16'hFFFF;
    y = 16'h5555;
    send(8'hA5, 8'h00);
    send(8'h01, 8'h14);
    send(8'h04, 8'hCD);
    send(8'h03, 8'h00);
    check("read_no_halt", 64'(dda_en), 64'd1);
    send(8'h07, 8'h80);

    // READ of a random snapshot, with the inputs scrambled right after sampling.
    xv = 16'($urandom);
    yv = 16'($urandom);
    x  = xv;
    y  = yv;
    send(8'h02, xv[15:8]);
    x = ~xv;
    y = ~yv;
    send(8'h00, xv[7:0]);
    send(8'hFF, yv[15:8]);
    send(8'h02, yv[7:0]);
    send(8'h05, 8'h00);
    check("read2_params", params, 64'h14DD_1234_14CD_C000);

    // Error handling: bad address, bad opcode, CLRERR.
    send(8'h01, 8'h81);
    send(8'h07, 8'hC0);
    send(8'h07, 8'h80);
    send(8'hFF, 8'hC0);
    send(8'h07, 8'h80);
    send(8'h01, 8'h81);
    send(8'h04, 8'hC0);
    send(8'h07, 8'h80);
    // Highest legal address.
    send(8'h01, 8'h81);
    send(8'h03, 8'h82);
    send(8'hBE, 8'h83);
    send(8'hEF, 8'h80);
    check("write_p3", params, 64'hBEEF_1234_14CD_C000);

    // HALT then STEP: exactly one high cycle.
    send(8'h04, 8'h00);
    check("halt_en", 64'(dda_en), 64'd0);
    send(8'h05, 8'h80);
    check("step_hi", 64'(dda_en), 64'd1);
    @(negedge clk);
    check("step_lo1", 64'(dda_en), 64'd0);
    @(negedge clk);
    check("step_lo2", 64'(dda_en), 64'd0);

    // Two back-to-back STEPs give two separate single-cycle pulses.
    @(negedge clk);
    strobe(8'h05, 8'h80);
    @(negedge clk);
    check("dstep_hi1", 64'(dda_en), 64'd1);
    strobe(8'h05, 8'h00);
    @(negedge clk);
    rx_dv = 1'b0;
    check("dstep_gap", 64'(dda_en), 64'd0);
    @(negedge clk);
    check("dstep_hi2", 64'(dda_en), 64'd1);
    @(negedge clk);
    check("dstep_lo", 64'(dda_en), 64'd0);

    // RUN, then STEP while running has no effect.
    send(8'h03, 8'h80);
    check("run_en", 64'(dda_en), 64'd1);
    send(8'h05, 8'h80);
    check("step_run0", 64'(dda_en), 64'd1);
    @(negedge clk);
    check("step_run1", 64'(dda_en), 64'd1);

    // RESTART pulse, with a CLRERR arriving during the pulse.
    @(negedge clk);
    strobe(8'h06, 8'h80);
    @(negedge clk);
    check("restart_hi", 64'(dda_rst), 64'd1);
    check("restart_en", 64'(dda_en),  64'd1);
    strobe(8'h07, 8'h80);
    @(negedge clk);
    rx_dv = 1'b0;
    check("restart_lo", 64'(dda_rst), 64'd0);

    // Reset in the middle of a WRITE abandons it; rx_dv during reset is ignored.
    rst_mark = dda_rst_cnt;
    send(8'h01, 8'h81);
    send(8'h00, 8'h82);
    send(8'hAA, 8'h83);
    rst_n   = 1'b0;
    rx_dv   = 1'b1;
    rx_byte = 8'h34;
    @(negedge clk);
    rst_n = 1'b1;
    rx_dv = 1'b0;
    check("mid_rst_tx_dv",   64'(tx_dv),   64'd0);
    check("mid_rst_tx_byte", 64'(tx_byte), 64'h00);
    check("mid_rst_params",  params,       PARAMS_RST);
    send(8'h03, 8'h80);
    check("post_rst_params", params,       PARAMS_RST);
    check("post_rst_en",     64'(dda_en),  64'd1);
    check("post_rst_no_rst", 64'(dda_rst_cnt), 64'(rst_mark));

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("tx_count",      64'(tx_pulses),    64'(rx_sent));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dda_spi_ctrl.md
DDA_SPI_CTRL -- requirements
Module: dda_spi_ctrl

Interface
REQ-001 Parameter N, default 16: DDA word width; only 16 is supported because the protocol is two bytes per word.
REQ-002 Parameter REG_SIZE, default 4: number of DDA parameter registers (icx, icy, k, d).
REQ-003 Port clk  in  1: single clock; every register updates on its rising edge.
REQ-004 Port rst_n  in  1: reset, synchronous and active-low.
REQ-005 Port rx_dv  in  1: one-cycle strobe from the SPI slave; a received byte is valid.
REQ-006 Port rx_byte  in  8: received SPI byte, valid while rx_dv=1.
REQ-007 Port tx_dv  out  1: one-cycle strobe to the SPI slave; load tx_byte.
REQ-008 Port tx_byte  out  8: next byte for MISO.
REQ-009 Port x  in  N: DDA state variable x.
REQ-010 Port y  in  N: DDA state variable y.
REQ-011 Port params  out  REG_SIZE*N: parameter register i drives params[i*N +: N].
REQ-012 Port dda_en  out  1: DDA integration enable.
REQ-013 Port dda_rst  out  1: active-high restart pulse to the DDA, which reloads icx/icy.

Function
REQ-014 Every output shall be registered; a response to an rx_dv seen in cycle t shall appear in cycle t+1.
REQ-015 The FSM shall have states IDLE(0), ADDR(1), DHI(2), DLO(3) and READ(4); bytes are processed only when rx_dv=1.
REQ-016 Every rx_dv, in any state, shall produce exactly one tx_dv pulse in cycle t+1.
REQ-017 Outside READ, tx_byte shall be the status byte {dda_en, err, 3'b000, state[2:0]}.
REQ-018 In IDLE, rx_byte is an opcode and shall be handled as follows:
- 0x01 WRITE: go to ADDR.
- 0x02 READ: capture snap={x,y}; tx_byte=snap[31:24]; go to READ with idx=1.
- 0x03 RUN: dda_en=1.
- 0x04 HALT: dda_en=0.
- 0x05 STEP: if dda_en=0, assert dda_en for exactly one cycle (t+1) and then return it to 0; if dda_en=1, take no action.
- 0x06 RESTART: dda_rst=1 for exactly cycle t+1; dda_en unchanged.
- 0x07 CLRERR: err=0.
- Any other value: err=1 (sticky); stay in IDLE.
REQ-019 In ADDR: if rx_byte<REG_SIZE, latch addr and go to DHI; otherwise set err=1 and go to IDLE.
REQ-020 In DHI: latch hi=rx_byte and go to DLO.
REQ-021 In DLO: write params[addr]={hi,rx_byte} in cycle t+1 and go to IDLE; a partial write shall never modify params.
REQ-022 In READ: the dummy byte with idx 1..3 loads snap byte idx (MSB first) and increments idx; the fourth dummy loads 0x00 and returns to IDLE. Dummy byte values are ignored and never decoded as opcodes.
REQ-023 snap shall be coherent: all four bytes come from the x/y sampled in the opcode cycle, whatever the DDA does afterwards.
REQ-024 A rx_dv arriving in the same cycle as a STEP or RESTART pulse shall be processed normally; a second STEP issued while a step pulse is active shall yield one more single-cycle pulse, never a merged pulse.
REQ-025 Writes to params shall take effect while the DDA runs; ICs apply on the next RESTART.

Reset
REQ-026 While rst_n=0 at a clock edge, the block shall set:
- state=IDLE, idx=0, err=0
- tx_dv=0, tx_byte=0x00, dda_rst=0, dda_en=1
- params[0]=0xC000, params[1]=0x14CD, params[2]=0x14DD, params[3]=0x14DD
REQ-027 Reset mid-command (ADDR/DHI/DLO/READ) shall abandon the command with no params write, and rx_dv shall be ignored during reset.

Verification
REQ-028 Sequence 0x01,0x02,0x12,0x34 -> params[2]=0x1234 one cycle after the fourth rx_dv; other params unchanged; four tx_dv pulses.
REQ-029 x=0xC000, y=0x14CD, then 0x02 followed by four dummy bytes, with x/y changed after the opcode -> tx_byte sequence 0xC0,0x00,0x14,0xCD,0x00; FSM ends in IDLE.
REQ-030 0x04 then 0x05 -> dda_en goes 0, then is high for exactly one cycle, then 0; 0x05 while running -> no change.
REQ-031 0x01,0x07 -> err=1, state IDLE, status=0x80|0x40; then 0x07 -> status 0x80.
REQ-032 0x01,0x00,0xAA then rst_n=0 for one cycle, then 0x03 -> params[0]=0xC000, dda_en=1, dda_rst never asserted.
